// File: rtl/mem_bus_arbiter_if.sv
// Shared-memory arbitration bus: three requester channels plus one memory port.
// The arbiter takes the slave view; requesters and memory together take the master view.
interface mem_bus_arbiter_if;
    logic [2:0]  s_valid;
    logic [2:0]  s_ready;
    logic [95:0] s_addr;
    logic [95:0] s_wdata;
    logic [11:0] s_wstrb;
    logic [31:0] s_rdata;
    logic        mem_valid;
    logic        mem_ready;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [3:0]  mem_wstrb;
    logic [31:0] mem_rdata;

    modport slave (
        input  s_valid, s_addr, s_wdata, s_wstrb, mem_ready, mem_rdata,
        output s_ready, s_rdata, mem_valid, mem_addr, mem_wdata, mem_wstrb
    );

    modport master (
        output s_valid, s_addr, s_wdata, s_wstrb, mem_ready, mem_rdata,
        input  s_ready, s_rdata, mem_valid, mem_addr, mem_wdata, mem_wstrb
    );
endinterface

// File: rtl/mem_bus_arbiter.sv
// Round-robin arbiter sharing one memory port between three requesters.
// Optional BUSY watchdog abort enabled by defining MEM_ARB_TIMEOUT_EN.
module mem_bus_arbiter #(
    parameter int TIMEOUT_CYCLES = 256
) (
    input  logic              clk,
    input  logic              resetn,
    mem_bus_arbiter_if.slave  bus,
    output logic [1:0]        grant_id,
    output logic              busy,
    output logic              timeout_err,
    input  logic              err_clr
);
    typedef enum logic {IDLE = 1'b0, BUSY = 1'b1} state_t;

    state_t     state;
    state_t     state_next;
    logic [1:0] last_grant;
    logic [1:0] winner;
    logic [1:0] cand;
    logic       done;
    logic       abort;

    // Scan from the slot after last_grant; the nearest requesting slot wins
    always_comb begin
        winner = last_grant;
        cand   = last_grant;
        for (int k = 3; k >= 1; k--) begin
            cand = 2'((int'(last_grant) + k) % 3);
            if (bus.s_valid[cand]) winner = cand;
        end
    end

    assign done = (state == BUSY) && bus.mem_ready;

`ifdef MEM_ARB_TIMEOUT_EN
    logic [15:0] tmo_cnt;

    assign abort = (state == BUSY) && !bus.mem_ready &&
                   (tmo_cnt == 16'(TIMEOUT_CYCLES - 1));

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            tmo_cnt     <= '0;
            timeout_err <= 1'b0;
        end else begin
            if (state != BUSY)        tmo_cnt <= '0;
            else if (!bus.mem_ready)  tmo_cnt <= tmo_cnt + 16'd1;
            if (abort)                timeout_err <= 1'b1;
            else if (err_clr)         timeout_err <= 1'b0;
        end
    end
`else
    localparam int unused_timeout = TIMEOUT_CYCLES;
    logic unused_err_clr;

    assign unused_err_clr = err_clr;
    assign abort          = 1'b0;
    assign timeout_err    = 1'b0;
`endif

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state         <= IDLE;
            last_grant    <= 2'd2;
            grant_id      <= 2'd0;
            bus.mem_addr  <= '0;
            bus.mem_wdata <= '0;
            bus.mem_wstrb <= '0;
        end else begin
            state <= state_next;
            if (state == IDLE && |bus.s_valid) begin
                grant_id      <= winner;
                bus.mem_addr  <= bus.s_addr[32*winner +: 32];
                bus.mem_wdata <= bus.s_wdata[32*winner +: 32];
                bus.mem_wstrb <= bus.s_wstrb[4*winner +: 4];
            end
            if (done || abort) last_grant <= grant_id;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (|bus.s_valid) state_next = BUSY;
            BUSY:    if (done || abort) state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // An abort completes the requester like a normal response, with zero data
    always_comb begin
        busy          = (state == BUSY);
        bus.mem_valid = (state == BUSY);
        bus.s_ready   = '0;
        bus.s_rdata   = '0;
        if (done) begin
            bus.s_ready = 3'b001 << grant_id;
            bus.s_rdata = bus.mem_rdata;
        end else if (abort) begin
            bus.s_ready = 3'b001 << grant_id;
        end
    end
endmodule
